dram_device_model: RTL and testbench

- Cycle-accurate responder for the DRAM command interface driven by the DRAM controller.
- Accepts cmd plus one-hot bank/row/column selects and a refresh request.
- Holds a bit array, tracks the open row per bank, and enforces activate and refresh timing.
- Returns read data after a fixed CAS latency and flags protocol violations; used as the memory end for controller integration and verification.

---
 rtl/dram_pkg.sv | 22 ++
 rtl/dram_device_model_if.sv | 29 ++
 rtl/dram_onehot_to_idx.sv | 20 ++
 rtl/dram_device_model.sv | 143 ++++++++++++++
 tb/tb_dram_device_model.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_pkg.sv
// Shared command encodings, FSM states and default timing for the DRAM device model.
package dram_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_WR  = 2'b11;

  typedef enum logic [1:0] {IDLE, READY, ACT_WAIT, REFRESH} dram_state_e;

  localparam int DEF_DATA_WIDTH   = 1;
  localparam int DEF_NUM_OF_BANKS = 8;
  localparam int DEF_NUM_OF_ROWS  = 128;
  localparam int DEF_NUM_OF_COLS  = 8;
  localparam int DEF_T_RCD        = 2;
  localparam int DEF_CAS_LAT      = 2;
  localparam int DEF_T_RFC        = 4;

  // Wide enough for any practical T_RCD / T_RFC.
  localparam int CNT_W = 8;

endpackage

// File: rtl/dram_device_model_if.sv
// Command/response bundle between the DRAM controller (master) and the device model (slave).
interface dram_device_model_if import dram_pkg::*; #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS
);
  logic [1:0]              cmd;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    refresh_req;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    busy;
  logic [NUM_OF_BANKS-1:0] open_banks;
  logic                    protocol_err;

  modport master (
    output cmd, bank_sel, row_sel, col_sel, wr_data, refresh_req,
    input  rd_data, rd_valid, busy, open_banks, protocol_err
  );

  modport slave (
    input  cmd, bank_sel, row_sel, col_sel, wr_data, refresh_req,
    output rd_data, rd_valid, busy, open_banks, protocol_err
  );
endinterface

// File: rtl/dram_onehot_to_idx.sv
// One-hot to binary index; valid is high only when exactly one input bit is set.
module dram_onehot_to_idx #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         in_vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     valid
);
  localparam int IW = $clog2(WIDTH);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_vec[i]) idx = idx | IW'(i);
    end
  end

  assign valid = $onehot(in_vec);

endmodule

// File: rtl/dram_device_model.sv
// Cycle-accurate DRAM responder: per-bank open row tracking, tRCD/tRFC busy windows,
// CAS-latency read pipe and a sticky protocol error flag.
//   state    | meaning
//   IDLE     | after reset or refresh, commands accepted
//   READY    | after ACT wait, commands accepted
//   ACT_WAIT | tRCD window after ACT, busy
//   REFRESH  | tRFC window after refresh, busy
module dram_device_model import dram_pkg::*; #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
  parameter int T_RCD        = DEF_T_RCD,
  parameter int CAS_LAT      = DEF_CAS_LAT,
  parameter int T_RFC        = DEF_T_RFC
) (
  input logic               clk,
  input logic               rst_b,
  dram_device_model_if.slave bus
);
  localparam int BW       = $clog2(NUM_OF_BANKS);
  localparam int RW       = $clog2(NUM_OF_ROWS);
  localparam int CW       = $clog2(NUM_OF_COLS);
  localparam int AW       = BW + RW + CW;
  localparam int MEM_SIZE = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;

  dram_state_e                         state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [NUM_OF_BANKS-1:0]             open_q, open_d;
  logic [NUM_OF_BANKS-1:0][RW-1:0]     row_q, row_d;
  logic                                err_q, err_d;
  logic [CAS_LAT-1:0]                  pv_q, pv_d;
  logic [CAS_LAT-1:0][DATA_WIDTH-1:0]  pd_q, pd_d;
  logic [DATA_WIDTH-1:0]               mem_q [MEM_SIZE];

  logic [BW-1:0] bank_idx;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          bank_v, row_v, col_v;
  logic          busy, rd_fire, wr_en;
  logic [AW-1:0] addr;

  dram_onehot_to_idx #(.WIDTH(NUM_OF_BANKS)) u_bank (
    .in_vec(bus.bank_sel), .idx(bank_idx), .valid(bank_v));
  dram_onehot_to_idx #(.WIDTH(NUM_OF_ROWS)) u_row (
    .in_vec(bus.row_sel), .idx(row_idx), .valid(row_v));
  dram_onehot_to_idx #(.WIDTH(NUM_OF_COLS)) u_col (
    .in_vec(bus.col_sel), .idx(col_idx), .valid(col_v));

  assign busy = (state_q == ACT_WAIT) || (state_q == REFRESH);
  assign addr = {bank_idx, row_q[bank_idx], col_idx};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    open_d  = open_q;
    row_d   = row_q;
    err_d   = err_q;
    rd_fire = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      ACT_WAIT: if (cnt_q == '0) state_d = READY; else cnt_d = cnt_q - CNT_W'(1);
      REFRESH:  if (cnt_q == '0) state_d = IDLE;  else cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase

    // Any rejected command leaves array, pipe and FSM untouched.
    if (busy) begin
      if (bus.refresh_req || bus.cmd != CMD_NOP) err_d = 1'b1;
    end else if (bus.refresh_req) begin
      if (bus.cmd != CMD_NOP) err_d = 1'b1;
      open_d  = '0;
      state_d = REFRESH;
      cnt_d   = CNT_W'(T_RFC - 1);
    end else begin
      case (bus.cmd)
        CMD_ACT: begin
          if (bank_v && row_v) begin
            open_d[bank_idx] = 1'b1;
            row_d[bank_idx]  = row_idx;
            state_d          = ACT_WAIT;
            cnt_d            = CNT_W'(T_RCD - 1);
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD, CMD_WR: begin
          if (bank_v && col_v && open_q[bank_idx]) begin
            rd_fire = (bus.cmd == CMD_RD);
            wr_en   = (bus.cmd == CMD_WR);
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pv_d    = pv_q;
    pd_d    = pd_q;
    pv_d[0] = rd_fire;
    pd_d[0] = mem_q[addr];
    for (int i = 1; i < CAS_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      open_q  <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      pv_q    <= '0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      open_q  <= open_d;
      row_q   <= row_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= bus.wr_data;
  end

  assign bus.rd_data      = pd_q[CAS_LAT-1];
  assign bus.rd_valid     = pv_q[CAS_LAT-1];
  assign bus.busy         = busy;
  assign bus.open_banks   = open_q;
  assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_dram_device_model.sv
// Directed plus randomized bench for dram_device_model against a behavioural reference model.
module tb_dram_device_model;
  localparam int NB = 8, NR = 128, NC = 8;
  localparam int T_RCD = 2, CAS_LAT = 2, T_RFC = 4;
  localparam logic [1:0] NOP = 2'b00, ACT = 2'b01, RD = 2'b10, WR = 2'b11;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  dram_device_model_if bus ();
  dram_device_model dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: array, open rows, remaining busy cycles, sticky error, scheduled reads.
  logic          mem_m   [NB][NR][NC];
  bit            known_m [NB][NR][NC];
  logic [NB-1:0] open_m;
  int            row_m [NB];
  int            busy_left;
  bit            err_m;
  int            edges = 0;
  typedef struct {int due; logic d; bit known;} rd_t;
  rd_t rdq[$];

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [NB-1:0] bsel(input int i);
    logic [NB-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NR-1:0] rsel(input int i);
    logic [NR-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] csel(input int i);
    logic [NC-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    open_m    = '0;
    busy_left = 0;
    err_m     = 1'b0;
    rdq.delete();
  endtask

  task automatic model_step(input logic [1:0] c, input logic [NB-1:0] b, input logic [NR-1:0] r,
                            input logic [NC-1:0] cl, input logic wd, input logic rf);
    int bi, ri, ci;
    bi = oh_idx(NR'(b));
    ri = oh_idx(r);
    ci = oh_idx(NR'(cl));
    if (busy_left > 0) begin
      if (rf || c != NOP) err_m = 1'b1;
      busy_left--;
    end else if (rf) begin
      if (c != NOP) err_m = 1'b1;
      open_m    = '0;
      busy_left = T_RFC;
    end else if (c == ACT) begin
      if ($onehot(b) && $onehot(r)) begin
        open_m[bi] = 1'b1;
        row_m[bi]  = ri;
        busy_left  = T_RCD;
      end else err_m = 1'b1;
    end else if (c == RD || c == WR) begin
      if ($onehot(b) && $onehot(cl) && open_m[bi]) begin
        if (c == RD)
          rdq.push_back('{due: edges + CAS_LAT - 1, d: mem_m[bi][row_m[bi]][ci],
                          known: known_m[bi][row_m[bi]][ci]});
        else begin
          mem_m[bi][row_m[bi]][ci]   = wd;
          known_m[bi][row_m[bi]][ci] = 1'b1;
        end
      end else err_m = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (rdq.size() > 0) && (rdq[0].due == edges);
    check_eq("busy", 32'(bus.busy), 32'(busy_left > 0));
    check_eq("open_banks", 32'(bus.open_banks), 32'(open_m));
    check_eq("protocol_err", 32'(bus.protocol_err), 32'(err_m));
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(ev));
    if (ev) begin
      if (rdq[0].known) check_eq("rd_data", 32'(bus.rd_data), 32'(rdq[0].d));
      void'(rdq.pop_front());
    end
  endtask

  task automatic cycle(input logic [1:0] c, input logic [NB-1:0] b, input logic [NR-1:0] r,
                       input logic [NC-1:0] cl, input logic wd, input logic rf);
    bus.cmd = c; bus.bank_sel = b; bus.row_sel = r; bus.col_sel = cl;
    bus.wr_data = wd; bus.refresh_req = rf;
    @(posedge clk);
    edges++;
    model_step(c, b, r, cl, wd, rf);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic nop(input int n);
    repeat (n) cycle(NOP, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drive_idle();
    bus.cmd = NOP; bus.bank_sel = '0; bus.row_sel = '0; bus.col_sel = '0;
    bus.wr_data = 1'b0; bus.refresh_req = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_b = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check_eq("rst_rd_data", 32'(bus.rd_data), 32'h0);
    rst_b = 1'b1;
  endtask

  task automatic rand_cycle();
    int r, bk, rw, cl;
    r  = $urandom_range(0, 99);
    bk = $urandom_range(0, NB - 1);
    rw = $urandom_range(0, 3);
    cl = $urandom_range(0, NC - 1);
    if (r < 2)
      cycle(2'($urandom_range(0, 3)), NB'($urandom), ($urandom_range(0, 1) != 0) ? rsel(rw) : '0,
            NC'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    else if (busy_left > 0) nop(1);
    else if (r < 5)  cycle(NOP, '0, '0, '0, 1'b0, 1'b1);
    else if (r < 20 || !open_m[bk]) cycle(ACT, bsel(bk), rsel(rw), '0, 1'b0, 1'b0);
    else if (r < 60) cycle(RD, bsel(bk), '0, csel(cl), 1'b0, 1'b0);
    else if (r < 85) cycle(WR, bsel(bk), '0, csel(cl), 1'($urandom), 1'b0);
    else nop(1);
  endtask

  initial begin
    drive_idle();
    rst_b = 1'b0;
    @(negedge clk);
    do_reset();

    // ACT bank 2 row 5, WR then RD the same location.
    cycle(ACT, 8'h04, rsel(5), '0, 1'b0, 1'b0);
    check_eq("t1_busy_after_act", 32'(bus.busy), 32'h1);
    nop(2);
    check_eq("t1_ready", 32'(bus.busy), 32'h0);
    cycle(WR, 8'h04, '0, 8'h08, 1'b1, 1'b0);
    cycle(RD, 8'h04, '0, 8'h08, 1'b0, 1'b0);
    check_eq("t1_no_early_valid", 32'(bus.rd_valid), 32'h0);
    nop(1);
    check_eq("t1_rd_valid", 32'(bus.rd_valid), 32'h1);
    check_eq("t1_rd_data", 32'(bus.rd_data), 32'h1);
    check_eq("t1_err", 32'(bus.protocol_err), 32'h0);
    nop(1);

    // Back-to-back reads of 1,0,1,1.
    cycle(WR, 8'h04, '0, csel(0), 1'b1, 1'b0);
    cycle(WR, 8'h04, '0, csel(1), 1'b0, 1'b0);
    cycle(WR, 8'h04, '0, csel(2), 1'b1, 1'b0);
    cycle(WR, 8'h04, '0, csel(3), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(RD, 8'h04, '0, csel(i), 1'b0, 1'b0);
    nop(3);

    // RD to closed bank 3: sticky error until reset.
    cycle(RD, bsel(3), '0, csel(0), 1'b0, 1'b0);
    nop(4);
    check_eq("t3_err_sticky", 32'(bus.protocol_err), 32'h1);
    do_reset();

    // WR during ACT wait is dropped.
    cycle(ACT, bsel(0), rsel(0), '0, 1'b0, 1'b0);
    nop(2);
    cycle(WR, bsel(0), '0, csel(0), 1'b0, 1'b0);
    cycle(ACT, bsel(0), rsel(0), '0, 1'b0, 1'b0);
    cycle(WR, bsel(0), '0, csel(0), 1'b1, 1'b0);
    nop(1);
    cycle(RD, bsel(0), '0, csel(0), 1'b0, 1'b0);
    nop(2);
    check_eq("t4_err", 32'(bus.protocol_err), 32'h1);
    do_reset();

    // Refresh with a read in flight, then RD to the refreshed bank.
    cycle(ACT, bsel(1), rsel(2), '0, 1'b0, 1'b0);
    nop(2);
    cycle(WR, bsel(1), '0, csel(1), 1'b1, 1'b0);
    cycle(RD, bsel(1), '0, csel(1), 1'b0, 1'b0);
    cycle(NOP, '0, '0, '0, 1'b0, 1'b1);
    check_eq("t5_inflight_valid", 32'(bus.rd_valid), 32'h1);
    nop(4);
    check_eq("t5_open_after_ref", 32'(bus.open_banks), 32'h0);
    cycle(RD, bsel(1), '0, csel(1), 1'b0, 1'b0);
    nop(2);
    do_reset();

    // Non-one-hot ACT, then async reset mid-refresh with a read in flight.
    cycle(ACT, bsel(2), rsel(1), '0, 1'b0, 1'b0);
    nop(2);
    cycle(ACT, 8'h06, rsel(1), '0, 1'b0, 1'b0);
    check_eq("t6_open_unchanged", 32'(bus.open_banks), 32'h04);
    cycle(RD, bsel(2), '0, csel(0), 1'b0, 1'b0);
    cycle(NOP, '0, '0, '0, 1'b0, 1'b1);
    #2 rst_b = 1'b0;
    model_reset();
    #1;
    check_eq("t6_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("t6_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    @(negedge clk);
    check_outputs();
    rst_b = 1'b1;
    nop(3);

    for (int round = 0; round < 4; round++) begin
      do_reset();
      repeat (500) rand_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
